// File: rtl/dual_issue_scheduler.sv
// Dual-issue decode scheduler: pairs, splits or stalls the IF/ID pair.
// Ports: flush, slot0/slot1 decode fields, EX load info -> issue0/1, stall_fetch, stats.
module dual_issue_scheduler #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid0,
  input  logic [REG_W-1:0] id_rs0,
  input  logic [REG_W-1:0] id_rt0,
  input  logic [REG_W-1:0] id_rd0,
  input  logic             id_regwrite0,
  input  logic             id_memread0,
  input  logic             id_memwrite0,
  input  logic             id_branch0,
  input  logic             id_valid1,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rt1,
  input  logic [REG_W-1:0] id_rd1,
  input  logic             id_regwrite1,
  input  logic             id_memread1,
  input  logic             id_memwrite1,
  input  logic             id_branch1,
  input  logic [REG_W-1:0] ex_rd0,
  input  logic [REG_W-1:0] ex_rd1,
  input  logic             ex_memread0,
  input  logic             ex_memread1,
  output logic             issue0,
  output logic             issue1,
  output logic             stall_fetch,
  output logic             state_second,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic {
    PAIR,
    SECOND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic lu0;
  logic lu1;
  logic raw;
  logic waw;
  logic memc;
  logic pairconf;
  logic inc_dual;
  logic inc_single;
  logic inc_stall;

  // A slot1 branch is irrelevant: only an older branch makes the younger
  // slot speculative.
  logic unused_br1;
  assign unused_br1 = id_branch1;

  function automatic logic lu_hit(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd,
    input logic             mr
  );
    return mr && (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

  assign lu0 = lu_hit(id_rs0, id_rt0, ex_rd0, ex_memread0)
             | lu_hit(id_rs0, id_rt0, ex_rd1, ex_memread1);
  assign lu1 = lu_hit(id_rs1, id_rt1, ex_rd0, ex_memread0)
             | lu_hit(id_rs1, id_rt1, ex_rd1, ex_memread1);

  assign raw  = id_regwrite0 && (id_rd0 != '0)
             && ((id_rd0 == id_rs1) || (id_rd0 == id_rt1));
  assign waw  = id_regwrite0 && id_regwrite1
             && (id_rd0 != '0) && (id_rd0 == id_rd1);
  assign memc = (id_memread0 | id_memwrite0)
             && (id_memread1 | id_memwrite1);

  assign pairconf = id_valid1
                 && (raw | waw | memc | id_branch0 | lu1);

  always_comb begin
    issue0      = 1'b0;
    issue1      = 1'b0;
    stall_fetch = 1'b0;
    inc_dual    = 1'b0;
    inc_single  = 1'b0;
    inc_stall   = 1'b0;
    state_nxt   = state;
    if (!rst) begin
      state_nxt = PAIR;
    end else if (flush) begin
      state_nxt = PAIR;
    end else begin
      unique case (state)
        PAIR: begin
          if (!id_valid0) begin
            state_nxt = PAIR;
          end else if (lu0) begin
            stall_fetch = 1'b1;
            inc_stall   = 1'b1;
          end else if (!id_valid1) begin
            issue0     = 1'b1;
            inc_single = 1'b1;
          end else if (pairconf) begin
            issue0      = 1'b1;
            stall_fetch = 1'b1;
            inc_single  = 1'b1;
            state_nxt   = SECOND;
          end else begin
            issue0   = 1'b1;
            issue1   = 1'b1;
            inc_dual = 1'b1;
          end
        end
        SECOND: begin
          if (lu1) begin
            stall_fetch = 1'b1;
            inc_stall   = 1'b1;
          end else begin
            issue1     = 1'b1;
            inc_single = 1'b1;
            state_nxt  = PAIR;
          end
        end
        default: state_nxt = PAIR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= PAIR;
      cnt_dual   <= '0;
      cnt_single <= '0;
      cnt_stall  <= '0;
    end else begin
      state <= state_nxt;
      if (inc_dual && (cnt_dual != '1))
        cnt_dual <= cnt_dual + 1'b1;
      if (inc_single && (cnt_single != '1))
        cnt_single <= cnt_single + 1'b1;
      if (inc_stall && (cnt_stall != '1))
        cnt_stall <= cnt_stall + 1'b1;
    end
  end

  assign state_second = (state == SECOND);

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler.
// Second instance with 2-bit counters exercises saturation.
module tb_dual_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       v0, v1;
  logic [4:0] rs0, rt0, rd0, rs1, rt1, rd1;
  logic       rw0, mr0, mw0, br0;
  logic       rw1, mr1, mw1, br1;
  logic [4:0] exrd0, exrd1;
  logic       exmr0, exmr1;

  logic        issue0, issue1, stall_fetch, state_second;
  logic [31:0] cnt_dual, cnt_single, cnt_stall;
  logic        s_i0, s_i1, s_stall, s_sec;
  logic [1:0]  s_dual, s_single, s_stl;

  int vectors = 0;
  int miscompares = 0;
  int e_dual = 0, e_single = 0, e_stall = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid0(v0), .id_rs0(rs0), .id_rt0(rt0), .id_rd0(rd0),
    .id_regwrite0(rw0), .id_memread0(mr0),
    .id_memwrite0(mw0), .id_branch0(br0),
    .id_valid1(v1), .id_rs1(rs1), .id_rt1(rt1), .id_rd1(rd1),
    .id_regwrite1(rw1), .id_memread1(mr1),
    .id_memwrite1(mw1), .id_branch1(br1),
    .ex_rd0(exrd0), .ex_rd1(exrd1),
    .ex_memread0(exmr0), .ex_memread1(exmr1),
    .issue0(issue0), .issue1(issue1),
    .stall_fetch(stall_fetch), .state_second(state_second),
    .cnt_dual(cnt_dual), .cnt_single(cnt_single),
    .cnt_stall(cnt_stall)
  );

  dual_issue_scheduler #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid0(v0), .id_rs0(rs0), .id_rt0(rt0), .id_rd0(rd0),
    .id_regwrite0(rw0), .id_memread0(mr0),
    .id_memwrite0(mw0), .id_branch0(br0),
    .id_valid1(v1), .id_rs1(rs1), .id_rt1(rt1), .id_rd1(rd1),
    .id_regwrite1(rw1), .id_memread1(mr1),
    .id_memwrite1(mw1), .id_branch1(br1),
    .ex_rd0(exrd0), .ex_rd1(exrd1),
    .ex_memread0(exmr0), .ex_memread1(exmr1),
    .issue0(s_i0), .issue1(s_i1),
    .stall_fetch(s_stall), .state_second(s_sec),
    .cnt_dual(s_dual), .cnt_single(s_single),
    .cnt_stall(s_stl)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic i0,
                      input logic i1, input logic st);
    check({tag, ".issue0"}, {31'd0, issue0}, {31'd0, i0});
    check({tag, ".issue1"}, {31'd0, issue1}, {31'd0, i1});
    check({tag, ".stall"}, {31'd0, stall_fetch}, {31'd0, st});
  endtask

  task automatic cnts(input string tag);
    check({tag, ".dual"}, cnt_dual, e_dual);
    check({tag, ".single"}, cnt_single, e_single);
    check({tag, ".stall_cnt"}, cnt_stall, e_stall);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot0(input logic v, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d,
                       input logic w, input logic r,
                       input logic m, input logic b);
    v0 = v; rs0 = s; rt0 = t; rd0 = d;
    rw0 = w; mr0 = r; mw0 = m; br0 = b;
  endtask

  task automatic slot1(input logic v, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d,
                       input logic w, input logic r,
                       input logic m, input logic b);
    v1 = v; rs1 = s; rt1 = t; rd1 = d;
    rw1 = w; mr1 = r; mw1 = m; br1 = b;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    exrd0 = 0; exrd1 = 0; exmr0 = 0; exmr1 = 0;
    slot0(1, 3, 4, 1, 1, 0, 0, 0);
    slot1(1, 5, 6, 2, 1, 0, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      outs("rst", 0, 0, 0);
      tick();
    end
    cnts("rst");
    check("rst.sec", {31'd0, state_second}, 0);

    rst = 1'b1; #1;
    outs("indep", 1, 1, 0);
    tick(); e_dual++;
    cnts("indep");

    slot0(1, 3, 4, 5, 1, 0, 0, 0);
    slot1(1, 5, 6, 2, 1, 0, 0, 0); #1;
    outs("raw.c0", 1, 0, 1);
    tick(); e_single++;
    check("raw.sec1", {31'd0, state_second}, 1);
    outs("raw.c1", 0, 1, 0);
    tick(); e_single++;
    check("raw.sec0", {31'd0, state_second}, 0);
    cnts("raw");

    slot0(1, 8, 0, 7, 1, 1, 0, 0);
    slot1(1, 7, 9, 10, 1, 0, 0, 0); #1;
    outs("ld.c0", 1, 0, 1);
    tick(); e_single++;
    exrd0 = 7; exmr0 = 1; #1;
    outs("ld.c1", 0, 0, 1);
    tick(); e_stall++;
    check("ld.sec", {31'd0, state_second}, 1);
    exmr0 = 0; #1;
    outs("ld.c2", 0, 1, 0);
    tick(); e_single++;
    cnts("ld");

    exrd0 = 0;
    slot0(1, 3, 4, 1, 1, 0, 0, 0);
    slot1(1, 5, 6, 2, 1, 0, 0, 0);
    exrd1 = 3; exmr1 = 1; #1;
    outs("lu0.c0", 0, 0, 1);
    tick(); e_stall++;
    check("lu0.sec", {31'd0, state_second}, 0);
    exmr1 = 0; #1;
    outs("lu0.c1", 1, 1, 0);
    tick(); e_dual++;
    slot0(1, 0, 4, 1, 1, 0, 0, 0);
    exrd1 = 0; exmr1 = 1; #1;
    outs("lu0.r0", 1, 1, 0);
    tick(); e_dual++;
    exmr1 = 0;
    cnts("lu0");

    slot0(1, 1, 2, 0, 0, 0, 0, 1);
    slot1(1, 5, 6, 2, 1, 0, 0, 0); #1;
    outs("fl.c0", 1, 0, 1);
    tick(); e_single++;
    check("fl.sec1", {31'd0, state_second}, 1);
    flush = 1'b1; #1;
    outs("fl.c1", 0, 0, 0);
    tick();
    check("fl.sec0", {31'd0, state_second}, 0);
    cnts("fl");
    slot0(1, 3, 4, 1, 1, 0, 0, 0); #1;
    outs("fl.pair", 0, 0, 0);
    tick();
    flush = 1'b0;

    slot0(1, 3, 4, 9, 1, 0, 0, 0);
    slot1(1, 5, 6, 9, 1, 0, 0, 0); #1;
    outs("waw.c0", 1, 0, 1);
    tick(); e_single++;
    outs("waw.c1", 0, 1, 0);
    tick(); e_single++;

    slot0(1, 3, 4, 0, 0, 0, 1, 0);
    slot1(1, 5, 0, 6, 1, 1, 0, 0); #1;
    outs("mem.c0", 1, 0, 1);
    tick(); e_single++;
    outs("mem.c1", 0, 1, 0);
    tick(); e_single++;

    slot0(1, 3, 4, 0, 1, 0, 0, 0);
    slot1(1, 0, 6, 2, 1, 0, 0, 0); #1;
    outs("r0dep", 1, 1, 0);
    tick(); e_dual++;

    slot1(0, 1, 1, 2, 1, 0, 0, 0); #1;
    outs("single", 1, 0, 0);
    tick(); e_single++;
    slot0(0, 1, 2, 3, 1, 0, 0, 0);
    slot1(1, 5, 6, 2, 1, 0, 0, 0); #1;
    outs("novalid", 0, 0, 0);
    tick();
    cnts("misc");
    check("sat.dual", {30'd0, s_dual}, 3);

    slot0(1, 3, 4, 5, 1, 0, 0, 0); #1;
    tick(); e_single++;
    check("rst2.pre", {31'd0, state_second}, 1);
    rst = 1'b0; #1;
    outs("rst2", 0, 0, 0);
    tick();
    check("rst2.sec", {31'd0, state_second}, 0);
    e_dual = 0; e_single = 0; e_stall = 0;
    cnts("rst2");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
